// File: rtl/divider_shift_sub_if.sv
// Divider request/result bundle: requester drives start and operands, divider returns status and results.
interface divider_shift_sub_if #(
    parameter int WORD_SIZE = 32
);
    logic                 start;
    logic [WORD_SIZE-1:0] dividend;
    logic [WORD_SIZE-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [WORD_SIZE-1:0] quotient;
    logic [WORD_SIZE-1:0] remainder;
    logic                 div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_shift_sub.sv
// Restoring shift-subtract divider, one quotient bit per clock; DIVIDER_SIGNED_EN selects two's complement operands.
// Latency WORD_SIZE cycles (WORD_SIZE+1 signed, 1 on divide-by-zero); done is a one-cycle strobe.
// start is ignored while busy; a new start is accepted in the done cycle.
module divider_shift_sub #(
    parameter int WORD_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    divider_shift_sub_if.slave  bus
);
    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   r_q;
    logic [W-1:0]   q_q;
    logic [W-1:0]   dvs_q;
    logic [W-1:0]   dvd_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   rem_q;
    logic           dbz_q;

    logic [W:0]     r_sh;
    logic [W-1:0]   r_d;
    logic [W-1:0]   q_d;

`ifdef DIVIDER_SIGNED_EN
    logic           neg_quo_q;
    logic           neg_rem_q;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction
`endif

    // Partial remainder stays below the divisor, so the difference always fits in W bits.
    always_comb begin
        r_sh = {r_q, q_q[W-1]};
        r_d  = r_sh[W-1:0];
        q_d  = {q_q[W-2:0], 1'b0};
        if (r_sh >= {1'b0, dvs_q}) begin
            r_d    = r_sh[W-1:0] - dvs_q;
            q_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        cnt_q   <= '0;
                        r_q     <= '0;
                        dvd_q   <= bus.dividend;
`ifdef DIVIDER_SIGNED_EN
                        q_q       <= mag(bus.dividend);
                        dvs_q     <= mag(bus.divisor);
                        neg_quo_q <= bus.dividend[W-1] ^ bus.divisor[W-1];
                        neg_rem_q <= bus.dividend[W-1];
`else
                        q_q     <= bus.dividend;
                        dvs_q   <= bus.divisor;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (dvs_q == '0) begin
                        quo_q   <= '1;
                        rem_q   <= dvd_q;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        r_q   <= r_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(W - 1)) begin
`ifdef DIVIDER_SIGNED_EN
                            state_q <= FIX;
`else
                            quo_q   <= q_d;
                            rem_q   <= r_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
`endif
                        end
                    end
                end
`ifdef DIVIDER_SIGNED_EN
                // Most-negative / -1 needs no special case: negating 2^(W-1) wraps back onto itself.
                FIX: begin
                    quo_q   <= neg_quo_q ? -q_q : q_q;
                    rem_q   <= neg_rem_q ? -r_q : r_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_shift_sub.sv
// Directed and randomized checks of divider_shift_sub results, latency, busy/done timing and reset abort.
module tb_divider_shift_sub;
    localparam int W = 32;
`ifdef DIVIDER_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    divider_shift_sub_if #(.WORD_SIZE(W)) bus ();

    divider_shift_sub #(.WORD_SIZE(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the edge that showed done (the done cycle).
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                           input int elat, input int pulse_at);
        int lat      = 0;
        int busy_cnt = 0;
        bit seen     = 1'b0;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy_acc"}, 64'(bus.busy), 64'd1);
        for (int i = 1; i <= W + 4 && !seen; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                lat  = i;
            end else if (bus.busy) begin
                busy_cnt++;
            end
            if (i == pulse_at && !seen) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(elat - 1));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_quotient"}, 64'(bus.quotient), 64'(eq));
        chk({tag, "_remainder"}, 64'(bus.remainder), 64'(er));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edz));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           late_done;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_quotient", 64'(bus.quotient), 64'd0);
        chk("rst_remainder", 64'(bus.remainder), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_div("dbz", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 0);
        run_div("dbz_clear", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT, 0);

`ifdef DIVIDER_SIGNED_EN
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT, 0);
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT, 0);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT, 0);
        run_div("s_m9_m4", 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'd2, 32'hFFFF_FFFF, 1'b0, LAT, 0);
        run_div("s_dbz", 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, 0);
`else
        run_div("u_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, 5);
        @(posedge clk); #1;
        chk("strobe_one_cycle", 64'(bus.done), 64'd0);
        chk("quotient_held", 64'(bus.quotient), 64'd14);
        run_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, 0);
        // Started from the done cycle above: back-to-back acceptance.
        run_div("u_5_max", 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, LAT, 0);
        run_div("u_big", 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, LAT, 0);
        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            run_div("rand", a, b, a / b, a % b, 1'b0, LAT, 0);
        end
`endif

        // Abort a running division with reset: everything clears, no done strobe follows.
        bus.start    = 1'b1;
        bus.dividend = 32'd200;
        bus.divisor  = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_quotient", 64'(bus.quotient), 64'd0);
        chk("abort_remainder", 64'(bus.remainder), 64'd0);
        chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
        late_done = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) late_done = 1'b1;
        end
        chk("abort_no_done", 64'(late_done), 64'd0);

        run_div("post_abort", 32'd200, 32'd3, 32'd66, 32'd2, 1'b0, LAT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/divider_shift_sub.md
# divider_shift_sub

Sequential restoring shift-subtract divider, the inverse of the combinational shift-add multiplier in the multiplier project. Accepts a dividend/divisor pair on a start pulse, retires one quotient bit per clock, and returns quotient and remainder with a one-cycle done strobe. Sits beside the multiplier as the arithmetic unit's divide path; a multiply-then-divide loopback is the standard cross-check between the two blocks.

## Interface
- WORD_SIZE, 32, operand/quotient/remainder width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- dividend  input  WORD_SIZE  numerator, sampled with start
- divisor  input  WORD_SIZE  denominator, sampled with start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle strobe: results valid
- quotient  output  WORD_SIZE  result quotient, held until next accepted start
- remainder  output  WORD_SIZE  result remainder, held until next accepted start
- div_by_zero  output  1  flag for the last result, held with it

## Operation
- FSM states: IDLE, RUN, FIX (signed build only), DONE.
- IDLE/DONE: start=1 → latch operands, clear done/div_by_zero, clear partial remainder R (WORD_SIZE+1 bits) and count, → RUN; busy=1.
- start while busy (RUN/FIX) ignored; latched operands unaffected by input changes.
- RUN step per cycle: R = {R[W-1:0], Q[W-1]}; Q = Q<<1; if R ≥ divisor: R = R − divisor, Q[0]=1. Count 0..W-1; on count W-1 → DONE (unsigned) or FIX (signed).
- DONE: quotient=Q, remainder=R[W-1:0], done=1 for exactly this cycle; busy=0; next cycle → IDLE unless start=1 (back-to-back accepted).
- Divisor zero: skip RUN; next edge → DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
- Invariant (no div-by-zero): dividend = quotient·divisor + remainder, remainder < divisor (unsigned).
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE.
- rst mid-operation: abort, all outputs to reset values on that edge, no done strobe.

## Timing
- start accepted at edge E0; busy=1 from after E0.
- Unsigned: result and done visible after edge E(WORD_SIZE), i.e. latency WORD_SIZE cycles; busy=0 in that same cycle.
- Signed: latency WORD_SIZE+1 (FIX cycle).
- Divide-by-zero: latency 1 cycle.
- Throughput: a new start may be applied in the done cycle; accepted on that edge.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DIVIDER_SIGNED_EN defined: operands two's complement. Operands converted to magnitudes at accept; FIX state negates quotient if signs differ, negates remainder if dividend negative (truncation toward zero, remainder takes dividend's sign). Overflow case (most-negative ÷ −1): quotient = most-negative, remainder=0, div_by_zero=0. Divide-by-zero: quotient all ones, remainder = dividend.
- Not defined: unsigned only, no FIX state, latency WORD_SIZE.

## Test plan
- Unsigned 100 ÷ 7 (W=32): start at E0 → done exactly after E32, quotient=14, remainder=2, div_by_zero=0; busy high for cycles 1..31 only.
- 0xFFFFFFFF ÷ 1 and 5 ÷ 0xFFFFFFFF → quotient 0xFFFFFFFF/rem 0, then quotient 0/rem 5.
- 1234 ÷ 0 → done one cycle after start, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1; next start of 9 ÷ 3 clears flag, gives 3 rem 0.
- start pulsed with new operands mid-RUN, then rst asserted at cycle 10 of a second op → first result unchanged by ignored start; after rst all outputs 0, no done strobe.
- Back-to-back: start held high across done cycle → second division accepted in done cycle, done again W cycles later; random 1000-pair check of the invariant.
- DIVIDER_SIGNED_EN: −7 ÷ 2 → quotient −3, remainder −1, latency 33; 0x80000000 ÷ −1 → quotient 0x80000000, remainder 0.
